// File: rtl/jclkctl.sv
// Manual clock controller for jclock: debounced step/run buttons drive a
// divided square wave sclk with free-run, single-step and halt modes.

module jclkctl_debounce #(
    parameter int DEB = 1_000_000
) (
    input  logic CLK,
    input  logic reset,
    input  logic btn,
    output logic click
);
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer feeding a stability counter; a click is the
    // single cycle in which the accepted level rises.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            click   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            click   <= 1'b0;
            if (sync_p1 != level) begin
                if (cnt == CW'(DEB - 1)) begin
                    level <= sync_p1;
                    cnt   <= '0;
                    click <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module jclkctl #(
    parameter int DIV          = 50_000_000,
    parameter int DEB          = 1_000_000,
    parameter int STEP_PERIODS = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        halt,
    output logic        sclk,
    output logic        busy,
    output logic        running,
    output logic [15:0] pcount
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW  = $clog2(STEP_PERIODS + 1);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DCW-1:0]   dcnt;
    logic [DCW-1:0]   dcnt_n;
    logic [RW-1:0]    rem;
    logic [RW-1:0]    rem_n;
    logic             run;
    logic             run_n;
    logic             pc_inc;
    logic             phase_end;
    logic             step_click;
    logic             run_click;

    jclkctl_debounce #(.DEB(DEB)) u_deb_step (
        .CLK   (CLK),
        .reset (reset),
        .btn   (btn_step),
        .click (step_click)
    );

    jclkctl_debounce #(.DEB(DEB)) u_deb_run (
        .CLK   (CLK),
        .reset (reset),
        .btn   (btn_run),
        .click (run_click)
    );

    assign phase_end = (dcnt == DCW'(DIV - 1));
    assign running   = run;

    // Decisions use the post-click run value so a run click starts sclk in
    // the following cycle and a stop request is honoured at the next LO end.
    always_comb begin
        run_n     = halt ? 1'b0 : (run ^ run_click);
        state_n   = state;
        dcnt_n    = dcnt;
        rem_n     = rem;
        pc_inc    = 1'b0;
        case (state)
            STOP: begin
                dcnt_n = '0;
                if (!halt) begin
                    if (run_n) begin
                        state_n = HI;
                    end else if (step_click) begin
                        rem_n   = RW'(STEP_PERIODS);
                        state_n = HI;
                    end
                end
            end
            HI: begin
                if (phase_end) begin
                    dcnt_n  = '0;
                    state_n = LO;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            LO: begin
                if (phase_end) begin
                    dcnt_n = '0;
                    pc_inc = 1'b1;
                    if (halt) begin
                        rem_n   = '0;
                        state_n = STOP;
                    end else if (run_n) begin
                        // Free-run absorbs any pending step burst.
                        rem_n   = '0;
                        state_n = HI;
                    end else if (rem > RW'(1)) begin
                        rem_n   = rem - 1'b1;
                        state_n = HI;
                    end else begin
                        rem_n   = '0;
                        state_n = STOP;
                    end
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            default: begin
                state_n = STOP;
                dcnt_n  = '0;
                rem_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state  <= STOP;
            dcnt   <= '0;
            rem    <= '0;
            run    <= 1'b0;
            sclk   <= 1'b0;
            busy   <= 1'b0;
            pcount <= 16'h0000;
        end else begin
            state  <= state_n;
            dcnt   <= dcnt_n;
            rem    <= rem_n;
            run    <= run_n;
            sclk   <= (state_n == HI);
            busy   <= (state_n != STOP);
            pcount <= pcount + {15'b0, pc_inc};
        end
    end
endmodule

// File: doc/jclkctl.md
# jclkctl

Manual clock controller sitting directly upstream of `jclock`. It turns the board clock `CLK` and two raw push-buttons into the slow square wave `sclk` that drives `jclock`. It supports free-running, single-step (one full CPU cycle per press) and halt operation. A completed-period counter is provided for the 7-segment display.

## Interface

Parameters:
- `DIV`, 50_000_000: `CLK` cycles per `sclk` half-period (high phase and low phase each last `DIV` cycles).
- `DEB`, 1_000_000: `CLK` cycles a synchronized button level must stay stable before it is accepted.
- `STEP_PERIODS`, 4: `sclk` periods emitted per single-step request (one full `jclock` cycle).

Ports:
- `CLK`  in  1  board clock; the only clock.
- `reset`  in  1  asynchronous, active-high; the block is one clock, with async active-high reset.
- `btn_step`  in  1  raw step button, asynchronous, may bounce.
- `btn_run`  in  1  raw run/stop toggle button, asynchronous, may bounce.
- `halt`  in  1  level halt request from CPU; synchronous to `CLK`.
- `sclk`  out  1  registered slow clock to `jclock`.
- `busy`  out  1  high while a period is in progress (state ≠ STOP).
- `running`  out  1  free-run mode flag.
- `pcount`  out  16  count of completed `sclk` periods.

## Operation

- Button path (per button):
  - 2-FF synchronizer.
  - Stability counter: the debounced level updates only after the synchronized level differs from it for `DEB` consecutive cycles. Any mismatch gap restarts the count.
  - The click is a one-`CLK` pulse on a debounced 0→1 transition. Release generates nothing.
- `run` register:
  - A run click toggles it in any state.
  - `halt` high forces it to 0 and overrides a simultaneous run click.
  - `running` = `run`.
- FSM states are STOP, HI and LO. Divider `dcnt` counts 0..`DIV`-1 within a phase. `rem` holds the step periods remaining.
- STOP:
  - `sclk` = 0.
  - If `halt` is high, stay in STOP.
  - Else if `run` is 1, go to HI.
  - Else on a step click, load `rem` = `STEP_PERIODS` and go to HI.
  - Step clicks are ignored outside STOP and whenever `run` is 1.
- HI: `sclk` = 1. After `DIV` cycles, go to LO.
- LO: `sclk` = 0. After `DIV` cycles, `pcount` increments (16-bit, wraps 0xFFFF→0x0000). Next state, in priority order:
  - `halt`: STOP.
  - `run`: HI.
  - `rem` > 1: decrement `rem`, go to HI.
  - Otherwise: set `rem` = 0, go to STOP.
- Periods are never truncated:
  - Clearing `run` mid-period (by click or `halt`) completes the current HI+LO, then stops.
  - In step mode, `rem` is not reloaded at that boundary.
- A run click during a step burst sets `run`. The burst then continues as free-run.
- `busy` = (state ≠ STOP).

## Timing

- Reset is asynchronous. Immediately on assertion:
  - `sclk` = 0, `busy` = 0, `running` = 0, `pcount` = 0.
  - State = STOP; `dcnt`, `rem`, synchronizers, debounced levels and debounce counters = 0.
- Raw press to click pulse: 2 + `DEB` cycles after the button settles.
- Click to `sclk` rise: the click is in cycle t and `sclk` = 1 from cycle t+1. All outputs are registered.
- Phase lengths:
  - `sclk` is high for exactly `DIV` cycles and low for exactly `DIV` cycles per period.
  - In free-run there is no extra idle cycle between periods.
- `pcount` updates in the same cycle that `sclk` would next rise.
- `busy` falls in the cycle after the final low phase completes.
- `halt` is sampled only in STOP and at the LO→next decision. `halt` pulses that occur wholly inside a period still clear `run`.

## Test plan

Bench parameters: `DIV`=2, `DEB`=4, `STEP_PERIODS`=4.

- Reset then idle 50 cycles: `sclk`=0, `busy`=0, `running`=0, `pcount`=0x0000 throughout.
- `btn_step` held high 20 cycles: exactly 4 periods of 2 high/2 low, starting 7 cycles after the press; `pcount`=4; `busy` high for 16 cycles then 0.
- `btn_step` bounces 1,0,1,0 with 3-cycle plateaus, then low: no `sclk` edge, `pcount` stays 0.
- Run click: continuous periods, `running`=1. Second run click during HI: that period finishes, then STOP; `pcount` is the number of full periods seen; no runt pulse.
- Free-run with `halt` raised mid-LO: stop at end of that LO, `running`=0. Step clicks while `halt`=1 give no `sclk` activity. Preload `pcount`=0xFFFF via a long run: the next period gives 0x0000.
- Async `reset` asserted mid-HI (not `CLK`-aligned): `sclk`, `busy`, `running` and `pcount` go 0 at once. After release, STOP until a new click.
